uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter between `NUM_REQ` byte producers. It sits between the requesters and the UART TX datapath, and is clocked by `sys_clk` alongside `baud_rate_gen`. It accepts one byte per frame through a valid/ready handshake, launches it with a one-cycle `tx_start`, waits for `tx_done_tick`, then enforces an inter-frame idle gap counted in baud ticks. Requesters can lock the channel for multi-byte packets using `req_last`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_BITS`, 8: frame payload width.
- `GAP_TICKS`, 16: baud ticks of idle line after each frame; 0 means no gap.
- `sys_clk` in 1: single system clock.
- `rst` in 1: reset, synchronous to `sys_clk`, active-high.
- `baud_tick` in 1: one-`sys_clk` pulse at the 16x oversampling rate, taken from `baud_rate_gen` `clk_out`.
- `req_valid` in `NUM_REQ`: requester i has a byte.
- `req_data` in `NUM_REQ*DATA_BITS`: byte of requester i at bits `[i*DATA_BITS +: DATA_BITS]`.
- `req_last` in `NUM_REQ`: byte is the last of its packet. 0 locks the channel to i.
- `req_ready` out `NUM_REQ`: one-hot accept; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `tx_start` out 1: one-cycle launch pulse to UART TX.
- `tx_din` out `DATA_BITS`: registered byte, stable from `tx_start` until `tx_done_tick`.
- `tx_done_tick` in 1: one-cycle pulse from UART TX at the end of the stop bit.
- `grant_id` out `clog2(NUM_REQ)`: index of the last accepted requester (registered).
- `locked` out 1: a packet lock is active.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, START, WAIT_DONE, GAP.
- **IDLE** (arbitration)
  - Eligible set: all `req_valid` bits, or only `req_valid[lock_id]` when `locked=1`.
  - Winner: first eligible index scanning `ptr, ptr+1, … mod NUM_REQ`.
  - `req_ready[winner]=1` combinationally, only in IDLE and only for the winner. All other bits are 0.
  - On a transfer: `tx_din <= req_data[winner]`, `grant_id <= winner`, next state START.
- **Lock and pointer**
  - An accepted byte with `req_last=0`: `locked <= 1`, `lock_id <= winner`, `ptr` unchanged.
  - An accepted byte with `req_last=1`: `locked <= 0`, `ptr <= (winner+1) mod NUM_REQ`.
  - While locked, other requesters stall even if the locked requester drops `req_valid`. There is no timeout.
- **START**: `tx_start=1` for exactly one cycle, then WAIT_DONE.
- **WAIT_DONE**
  - `tx_done_tick` is observed only in this state. It is ignored in all other states.
  - On `tx_done_tick`: `gap_cnt <= 0`, then GAP, or IDLE directly if `GAP_TICKS=0`.
- **GAP**
  - `gap_cnt` increments on each `baud_tick`.
  - When `baud_tick` arrives with `gap_cnt == GAP_TICKS-1`, go to IDLE.
  - `gap_cnt` width is `clog2(GAP_TICKS+1)`. No wrap is possible.
- **Reset**
  - `rst=1` at any cycle (including mid-frame) on the next edge forces: state IDLE, `tx_start=0`, `tx_din=0`, `grant_id=0`, `ptr=0`, `lock_id=0`, `locked=0`, `gap_cnt=0`, `busy=0`, `req_ready=0`.
  - During `rst=1`, `req_ready` is held at all-zeros.

## Timing
- Acceptance in cycle n (IDLE, valid & ready) gives `tx_start` in cycle n+1 and WAIT_DONE from n+2.
- `tx_done_tick` in cycle m gives GAP from m+1. The earliest next acceptance is m+1 if `GAP_TICKS=0`.
- With `GAP_TICKS>0`, the next acceptance is no earlier than the cycle after the `GAP_TICKS`-th `baud_tick` following `tx_done_tick`.
- A `baud_tick` coincident with `tx_done_tick` is not counted.
- At most one byte is accepted per frame. `req_ready` is never asserted outside IDLE.
- `req_data` is sampled only on the transfer cycle. It may change afterwards.

## Test plan
- **Single byte**: req 2 sends 0x9A, last=1, GAP_TICKS=16 -> `req_ready[2]` in the same cycle, `tx_start` one cycle later with `tx_din=0x9A`. After `tx_done_tick`, `busy` stays high for 16 `baud_tick`s, then `ptr=3`.
- **Fair rotation**: all four requests valid continuously with last=1, after reset -> grant order 0,1,2,3,0. `grant_id` follows that order, and each byte appears on `tx_din` once.
- **Packet lock**: req 1 sends 0x11 (last=0), 0x22 (last=0), 0x33 (last=1) while req 0 and req 3 are valid -> bytes 0x11, 0x22, 0x33 are sent back to back with `locked=1`. Then req 3 wins (`ptr=2`, first eligible is 3).
- **Lock stall**: locked req 1 drops valid for 5 frame-times while req 0 is valid -> no `tx_start` and `req_ready=0`. Req 1 resumes and is served first.
- **Gap boundary**: GAP_TICKS=0 -> acceptance possible in the cycle after `tx_done_tick`. A `tx_done_tick` injected in IDLE/START has no effect.
- **Reset mid-frame**: `rst` pulsed during WAIT_DONE with `locked=1` -> next cycle all outputs are 0 and state is IDLE. A later request from req 3 with req 0 idle is granted with `ptr=0`.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one UART transmitter between byte producers
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int GAP_TICKS = 16
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic                         baud_tick,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_start,
  output logic [DATA_BITS-1:0]         tx_din,
  input  logic                         tx_done_tick,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         locked,
  output logic                         busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  // A zero-tick gap never enters GAP, but the counter still needs one bit to exist.
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [ID_W:0]    NREQ     = (ID_W+1)'(NUM_REQ);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    GAP
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    lock_id;
  logic [GAP_W-1:0]   gap_cnt;

  logic [NUM_REQ-1:0] eligible;
  logic [ID_W:0]      scan_idx;
  logic [ID_W:0]      ptr_inc;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    next_ptr;
  logic               found;
  logic               accept;

  // Pick the first eligible requester at or after ptr; a lock narrows the field to lock_id.
  always_comb begin
    eligible = locked ? (req_valid & (NUM_REQ'(1) << lock_id)) : req_valid;
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      if (!found && eligible[scan_idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[ID_W-1:0];
      end
    end
  end

  // Pointer moves one past the winner when its packet ends, wrapping at NUM_REQ.
  always_comb begin
    ptr_inc = {1'b0, winner} + (ID_W+1)'(1);
    if (ptr_inc >= NREQ) begin
      ptr_inc = '0;
    end
    next_ptr = ptr_inc[ID_W-1:0];
  end

  // Ready only to the winner, only while idle, and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && found) begin
      req_ready = NUM_REQ'(1) << winner;
    end
    accept = |(req_valid & req_ready);
    busy   = (state != IDLE);
  end

  // Frame sequencer: accept, launch, wait for stop bit, then hold the line idle for the gap.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_din   <= '0;
      grant_id <= '0;
      ptr      <= '0;
      lock_id  <= '0;
      locked   <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_din   <= req_data[winner*DATA_BITS +: DATA_BITS];
            grant_id <= winner;
            if (req_last[winner]) begin
              locked <= 1'b0;
              ptr    <= next_ptr;
            end else begin
              locked  <= 1'b1;
              lock_id <= winner;
            end
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done_tick) begin
            gap_cnt <= '0;
            state   <= (GAP_TICKS == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (baud_tick) begin
            if (gap_cnt == GAP_LAST) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scenario and randomized checks of uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 16;

  logic            sys_clk      = 1'b0;
  logic            rst          = 1'b1;
  logic            baud_tick    = 1'b0;
  logic            tx_done_tick = 1'b0;
  logic [N-1:0]    req_valid    = '0;
  logic [N*DW-1:0] req_data     = '0;
  logic [N-1:0]    req_last     = '0;
  logic [N-1:0]    req_ready;
  logic            tx_start, locked, busy;
  logic [DW-1:0]   tx_din;
  logic [1:0]      grant_id;

  logic            z_done  = 1'b0;
  logic [N-1:0]    z_valid = '0;
  logic [N*DW-1:0] z_data  = '0;
  logic [N-1:0]    z_last  = '0;
  logic [N-1:0]    z_ready;
  logic            z_start, z_locked, z_busy;
  logic [DW-1:0]   z_din;
  logic [1:0]      z_grant;

  int vectors     = 0;
  int miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .GAP_TICKS(GAP)) u_dut (
    .sys_clk(sys_clk), .rst(rst), .baud_tick(baud_tick),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick),
    .grant_id(grant_id), .locked(locked), .busy(busy)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .GAP_TICKS(0)) u_dut_nogap (
    .sys_clk(sys_clk), .rst(rst), .baud_tick(baud_tick),
    .req_valid(z_valid), .req_data(z_data), .req_last(z_last), .req_ready(z_ready),
    .tx_start(z_start), .tx_din(z_din), .tx_done_tick(z_done),
    .grant_id(z_grant), .locked(z_locked), .busy(z_busy)
  );

  // Reference model of the main instance: channel phases plus round-robin bookkeeping.
  int          m_ptr = 0, m_lock_id = 0, m_grant = 0, m_gap_left = 0;
  bit          m_locked = 0, m_launch = 0, m_frame = 0;
  logic [7:0]  m_din = 8'h00;

  function automatic bit m_free();
    return !m_launch && !m_frame && (m_gap_left == 0);
  endfunction

  function automatic int m_winner(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v[i] && (!m_locked || i == m_lock_id)) return i;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (rst) begin
      m_ptr = 0; m_lock_id = 0; m_grant = 0; m_gap_left = 0;
      m_locked = 0; m_launch = 0; m_frame = 0; m_din = 8'h00;
      return;
    end
    w = m_free() ? m_winner(req_valid) : -1;
    if (w >= 0) begin
      m_din   = req_data[w*DW +: DW];
      m_grant = w;
      if (req_last[w]) begin
        m_locked = 0;
        m_ptr    = (w + 1) % N;
      end else begin
        m_locked  = 1;
        m_lock_id = w;
      end
      m_launch = 1;
    end else if (m_launch) begin
      m_launch = 0;
      m_frame  = 1;
    end else if (m_frame) begin
      if (tx_done_tick) begin
        m_frame    = 0;
        m_gap_left = GAP;
      end
    end else if (m_gap_left > 0 && baud_tick) begin
      m_gap_left--;
    end
  endtask

  task automatic clk_edge();
    model_edge();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic [N-1:0] l,
                       input logic b, input logic dn);
    req_valid = v; req_data = d; req_last = l; baud_tick = b; tx_done_tick = dn;
  endtask

  task automatic run_until_free(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic [N-1:0] l);
    for (int i = 0; i < 400 && !m_free(); i++) begin
      drive(v, d, l, 1'b1, m_frame);
      clk_edge();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, '0, '0, 1'b0, 1'b0);
    z_valid = '0; z_done = 1'b0;
    clk_edge(); clk_edge();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive('1, {8'h44, 8'h33, 8'h22, 8'h11}, '1, 1'b1, 1'b1);
    z_valid = '1;
    #1;
    vectors++;
    if (req_ready !== '0 || z_ready !== '0) begin
      miscompares++;
      $display("FAIL reset_ready req_ready=%b z_ready=%b required 0000", req_ready, z_ready);
    end
    clk_edge(); clk_edge();
    vectors++;
    if (tx_start !== 1'b0 || tx_din !== 8'h00 || grant_id !== 2'd0 || locked !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_regs start=%b din=%h grant=%0d locked=%b busy=%b required all 0",
               tx_start, tx_din, grant_id, locked, busy);
    end
    vectors++;
    if (z_start !== 1'b0 || z_din !== 8'h00 || z_grant !== 2'd0 || z_locked !== 1'b0 || z_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_regs_nogap start=%b din=%h grant=%0d locked=%b busy=%b required all 0",
               z_start, z_din, z_grant, z_locked, z_busy);
    end
    rst = 1'b0;
    drive('0, '0, '0, 1'b0, 1'b0);
    z_valid = '0; z_done = 1'b0;
  endtask

  task automatic test_single_byte();
    logic [N*DW-1:0] d;
    int bad;
    d = '0; d[2*DW +: DW] = 8'h9A;
    drive(4'b0100, d, '1, 1'b0, 1'b0);
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++; $display("FAIL single_ready got=%b required 0100", req_ready);
    end
    clk_edge();
    drive('0, '0, '0, 1'b0, 1'b0);
    vectors++;
    if (tx_start !== 1'b1 || tx_din !== 8'h9A || grant_id !== 2'd2 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_launch start=%b din=%h grant=%0d busy=%b required 1 9a 2 1", tx_start, tx_din, grant_id, busy);
    end
    clk_edge();
    vectors++;
    if (tx_start !== 1'b0 || tx_din !== 8'h9A) begin
      miscompares++; $display("FAIL single_pulse start=%b din=%h required 0 9a", tx_start, tx_din);
    end
    clk_edge(); clk_edge();
    drive('0, '0, '0, 1'b1, 1'b1);
    clk_edge();
    bad = -1;
    for (int t = 0; t < GAP; t++) begin
      if (busy !== 1'b1 && bad < 0) bad = t;
      drive('0, '0, '0, 1'b1, 1'b0); clk_edge();
      drive('0, '0, '0, 1'b0, 1'b0); clk_edge();
    end
    vectors++;
    if (bad >= 0) begin
      miscompares++; $display("FAIL single_gap_busy busy low before tick %0d, required high for %0d ticks", bad, GAP);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL single_gap_end busy=%b required 0", busy);
    end
    drive(4'b1001, {8'h93, 8'h00, 8'h00, 8'h90}, '1, 1'b0, 1'b0);
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++; $display("FAIL single_ptr got=%b required 1000", req_ready);
    end
    clk_edge();
    run_until_free('0, '0, '0);
  endtask

  task automatic test_fair_rotation();
    logic [N*DW-1:0] d;
    int e;
    do_reset();
    d = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int f = 0; f < 5; f++) begin
      e = f % N;
      run_until_free('1, d, '1);
      drive('1, d, '1, 1'b1, 1'b0);
      #1;
      vectors++;
      if (req_ready !== N'(1 << e)) begin
        miscompares++; $display("FAIL fair_ready frame=%0d got=%b required one-hot %0d", f, req_ready, e);
      end
      clk_edge();
      vectors++;
      if (tx_start !== 1'b1 || grant_id !== 2'(e) || tx_din !== (8'hA0 + 8'(e))) begin
        miscompares++;
        $display("FAIL fair_launch frame=%0d start=%b grant=%0d din=%h required 1 %0d %h",
                 f, tx_start, grant_id, tx_din, e, 8'hA0 + 8'(e));
      end
    end
    run_until_free('0, '0, '0);
  endtask

  task automatic test_packet_lock();
    logic [N*DW-1:0] d;
    logic [N-1:0]    l;
    logic [7:0]      pk [3];
    pk[0] = 8'h11; pk[1] = 8'h22; pk[2] = 8'h33;
    do_reset();
    d = '0; d[7:0] = 8'h55;
    drive(4'b0001, d, 4'b0001, 1'b0, 1'b0);
    clk_edge();
    for (int b = 0; b < 3; b++) begin
      d = {8'hD3, 8'h00, pk[b], 8'hD0};
      l = 4'b1111; l[1] = (b == 2);
      run_until_free(4'b1011, d, l);
      drive(4'b1011, d, l, 1'b1, 1'b0);
      #1;
      vectors++;
      if (req_ready !== 4'b0010) begin
        miscompares++; $display("FAIL lock_ready byte=%0d got=%b required 0010", b, req_ready);
      end
      clk_edge();
      vectors++;
      if (tx_din !== pk[b] || grant_id !== 2'd1 || locked !== (b < 2)) begin
        miscompares++;
        $display("FAIL lock_byte byte=%0d din=%h grant=%0d locked=%b required %h 1 %b", b, tx_din, grant_id, locked, pk[b], (b < 2));
      end
    end
    d = {8'hD3, 8'h00, 8'h00, 8'hD0};
    run_until_free(4'b1001, d, '1);
    drive(4'b1001, d, '1, 1'b1, 1'b0);
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++; $display("FAIL lock_release got=%b required 1000", req_ready);
    end
    clk_edge();
    run_until_free('0, '0, '0);
  endtask

  task automatic test_lock_stall();
    logic [N*DW-1:0] d;
    int bad_cycles;
    do_reset();
    d = '0; d[15:8] = 8'h44; d[7:0] = 8'h0F;
    drive(4'b0010, d, 4'b0000, 1'b0, 1'b0);
    clk_edge();
    run_until_free(4'b0001, d, 4'b0001);
    bad_cycles = 0;
    for (int c = 0; c < 200; c++) begin
      drive(4'b0001, d, 4'b0001, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      if (req_ready !== '0 || tx_start !== 1'b0 || busy !== 1'b0 || locked !== 1'b1) bad_cycles++;
      clk_edge();
    end
    vectors++;
    if (bad_cycles != 0) begin
      miscompares++; $display("FAIL lock_stall active cycles=%0d required 0", bad_cycles);
    end
    d[15:8] = 8'h45;
    drive(4'b0011, d, 4'b0011, 1'b0, 1'b0);
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++; $display("FAIL stall_resume got=%b required 0010", req_ready);
    end
    clk_edge();
    vectors++;
    if (tx_din !== 8'h45 || locked !== 1'b0 || grant_id !== 2'd1) begin
      miscompares++; $display("FAIL stall_byte din=%h locked=%b grant=%0d required 45 0 1", tx_din, locked, grant_id);
    end
    run_until_free(4'b0001, d, 4'b0001);
    drive(4'b0001, d, 4'b0001, 1'b0, 1'b0);
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL stall_next got=%b required 0001", req_ready);
    end
    clk_edge();
    run_until_free('0, '0, '0);
  endtask

  task automatic test_reset_mid_frame();
    logic [N*DW-1:0] d;
    do_reset();
    d = '0; d[15:8] = 8'h71; d[23:16] = 8'h72;
    drive(4'b0010, d, 4'b0010, 1'b0, 1'b0);
    clk_edge();
    run_until_free(4'b0100, d, 4'b0000);
    drive(4'b0100, d, 4'b0000, 1'b0, 1'b0);
    clk_edge();
    drive('0, d, '0, 1'b0, 1'b0);
    clk_edge(); clk_edge();
    vectors++;
    if (locked !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd2) begin
      miscompares++; $display("FAIL midrst_setup locked=%b busy=%b grant=%0d required 1 1 2", locked, busy, grant_id);
    end
    rst = 1'b1;
    drive('1, d, '1, 1'b1, 1'b1);
    #1;
    vectors++;
    if (req_ready !== '0) begin
      miscompares++; $display("FAIL midrst_ready got=%b required 0000", req_ready);
    end
    clk_edge();
    rst = 1'b0;
    drive('0, '0, '0, 1'b0, 1'b0);
    vectors++;
    if (tx_start !== 1'b0 || tx_din !== 8'h00 || grant_id !== 2'd0 || locked !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_regs start=%b din=%h grant=%0d locked=%b busy=%b required all 0", tx_start, tx_din, grant_id, locked, busy);
    end
    d = {8'h83, 8'h00, 8'h81, 8'h00};
    drive(4'b1010, d, '1, 1'b0, 1'b0);
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++; $display("FAIL midrst_ptr got=%b required 0010", req_ready);
    end
    clk_edge();
    run_until_free('0, '0, '0);
    d = '0; d[31:24] = 8'hC3;
    drive(4'b1000, d, 4'b1000, 1'b0, 1'b0);
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++; $display("FAIL midrst_req3 got=%b required 1000", req_ready);
    end
    clk_edge();
    vectors++;
    if (tx_start !== 1'b1 || tx_din !== 8'hC3 || grant_id !== 2'd3) begin
      miscompares++; $display("FAIL midrst_launch start=%b din=%h grant=%0d required 1 c3 3", tx_start, tx_din, grant_id);
    end
    run_until_free('0, '0, '0);
  endtask

  task automatic test_gap_zero();
    do_reset();
    z_data = '0; z_data[7:0] = 8'h5A; z_data[15:8] = 8'h6B;
    z_last = '1;
    z_done = 1'b1;
    clk_edge();
    z_done = 1'b0;
    vectors++;
    if (z_busy !== 1'b0 || z_start !== 1'b0) begin
      miscompares++; $display("FAIL nogap_idle_done busy=%b start=%b required 0 0", z_busy, z_start);
    end
    z_valid = 4'b0001;
    #1;
    vectors++;
    if (z_ready !== 4'b0001) begin
      miscompares++; $display("FAIL nogap_ready got=%b required 0001", z_ready);
    end
    clk_edge();
    z_valid = '0;
    z_done  = 1'b1;
    vectors++;
    if (z_start !== 1'b1 || z_din !== 8'h5A) begin
      miscompares++; $display("FAIL nogap_launch start=%b din=%h required 1 5a", z_start, z_din);
    end
    clk_edge();
    z_done = 1'b0;
    clk_edge(); clk_edge();
    vectors++;
    if (z_busy !== 1'b1) begin
      miscompares++; $display("FAIL nogap_start_done busy=%b required 1", z_busy);
    end
    z_done = 1'b1;
    clk_edge();
    z_done  = 1'b0;
    z_valid = 4'b0010;
    #1;
    vectors++;
    if (z_busy !== 1'b0 || z_ready !== 4'b0010) begin
      miscompares++; $display("FAIL nogap_accept busy=%b ready=%b required 0 0010", z_busy, z_ready);
    end
    clk_edge();
    z_valid = '0;
    vectors++;
    if (z_start !== 1'b1 || z_din !== 8'h6B || z_grant !== 2'd1) begin
      miscompares++; $display("FAIL nogap_second start=%b din=%h grant=%0d required 1 6b 1", z_start, z_din, z_grant);
    end
    clk_edge(); clk_edge();
    z_done = 1'b1;
    clk_edge();
    z_done = 1'b0;
  endtask

  task automatic test_random();
    int          left [N];
    logic [7:0]  cur [N];
    int          done_cd;
    int          w;
    logic [N-1:0] exp_ready;
    do_reset();
    for (int i = 0; i < N; i++) begin
      left[i] = $urandom_range(1, 3);
      cur[i]  = 8'($urandom);
    end
    done_cd = 0;
    for (int c = 0; c < 3000; c++) begin
      vectors++;
      if (tx_start !== m_launch || busy !== !m_free() || locked !== m_locked ||
          grant_id !== 2'(m_grant) || tx_din !== m_din) begin
        miscompares++;
        $display("FAIL rand_regs cycle=%0d start=%b/%b busy=%b/%b locked=%b/%b grant=%0d/%0d din=%h/%h (got/required)",
                 c, tx_start, m_launch, busy, !m_free(), locked, m_locked, grant_id, m_grant, tx_din, m_din);
      end
      if (m_launch) done_cd = $urandom_range(0, 5);
      for (int i = 0; i < N; i++) begin
        req_valid[i]          = ($urandom_range(0, 3) != 0);
        req_data[i*DW +: DW]  = cur[i];
        req_last[i]           = (left[i] == 1);
      end
      baud_tick = ($urandom_range(0, 2) == 0);
      if (m_frame) begin
        tx_done_tick = (done_cd == 0);
        if (done_cd > 0) done_cd--;
      end else begin
        tx_done_tick = ($urandom_range(0, 7) == 0);
      end
      #1;
      w = m_free() ? m_winner(req_valid) : -1;
      exp_ready = (w >= 0) ? N'(1 << w) : '0;
      vectors++;
      if (req_ready !== exp_ready) begin
        miscompares++; $display("FAIL rand_ready cycle=%0d got=%b required %b", c, req_ready, exp_ready);
      end
      if (w >= 0) begin
        left[w]--;
        if (left[w] == 0) left[w] = $urandom_range(1, 3);
        cur[w] = 8'($urandom);
      end
      clk_edge();
    end
    run_until_free('0, '0, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge sys_clk);
    #1;
    test_reset();
    test_single_byte();
    test_fair_rotation();
    test_packet_lock();
    test_lock_stall();
    test_reset_mid_frame();
    test_gap_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
